// File: rtl/booth_pkg.sv
// Shared widths and FSM state type for the Booth product accumulator.
package booth_pkg;
  localparam int PROD_W = 32;
  localparam int OUT_W  = 32;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/booth_sat.sv
// Clips a wide signed accumulator sum into the signed OUT_W-bit range.
module booth_sat
  import booth_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] sat_sum,
  output logic             sat
);
  logic pos_ovf, neg_ovf;

  // In range only when every bit above the OUT_W sign bit matches the true sign.
  assign pos_ovf = !sum[ACC_W-1] && (sum[ACC_W-2:OUT_W-1] != '0);
  assign neg_ovf =  sum[ACC_W-1] && (sum[ACC_W-2:OUT_W-1] != '1);
  assign sat     = pos_ovf || neg_ovf;

  always_comb begin
    sat_sum = sum[OUT_W-1:0];
    if (pos_ovf)      sat_sum = {1'b0, {(OUT_W-1){1'b1}}};
    else if (neg_ovf) sat_sum = {1'b1, {(OUT_W-1){1'b0}}};
  end
endmodule

// File: rtl/booth_accum.sv
// Frame accumulator for signed products; emits one sum per LEN beats or in_last.
// Optional output saturation is enabled with BOOTH_ACCUM_SAT_EN.
module booth_accum
  import booth_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          in_prod,
  input  logic                       in_last,
  input  logic                       clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_sum,
  output logic [$clog2(LEN+1)-1:0]   out_cnt,
  output logic                       out_sat
);
  localparam int CNT_W = $clog2(LEN+1);

  state_t            state;
  logic [ACC_W-1:0]  acc, sum_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              is_final;
  logic [OUT_W-1:0]  res_sum;
  logic              res_sat;

  assign sum_nxt  = acc + {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign is_final = (cnt_nxt == CNT_W'(LEN)) || in_last;

`ifdef BOOTH_ACCUM_SAT_EN
  booth_sat #(.ACC_W(ACC_W)) u_sat (
    .sum     (sum_nxt),
    .sat_sum (res_sum),
    .sat     (res_sat)
  );
`else
  assign res_sum = sum_nxt[OUT_W-1:0];
  assign res_sat = 1'b0;
`endif

  // in_ready comes straight from a flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (clr) begin
            acc <= '0;
            cnt <= '0;
          end else if (in_valid && in_ready) begin
            acc <= sum_nxt;
            cnt <= cnt_nxt;
            if (is_final) begin
              out_sum   <= res_sum;
              out_cnt   <= cnt_nxt;
              out_sat   <= res_sat;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // clr and a handshake both retire the held result.
          if (clr || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_accum.sv
// Directed scoreboard bench for booth_accum (LEN=8, ACC_W=40).
module tb_booth_accum;
  localparam int LEN   = 8;
  localparam int ACC_W = 40;
  localparam int CNT_W = $clog2(LEN+1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_prod = '0;
  logic             in_last = 1'b0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;

  typedef struct {
    logic [31:0]      sum;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  booth_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] p, input logic last, input logic c);
    int t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_prod = p; in_last = last; clr = c;
    tick();
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input int c, input logic sat);
    exp_t e;
    e.sum = s; e.cnt = CNT_W'(c); e.sat = sat;
    q.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(q.size()), 64'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"}, 64'(out_sum), 64'(e.sum));
      chk({tag, "_cnt"}, 64'(out_cnt), 64'(e.cnt));
      chk({tag, "_sat"}, 64'(out_sat), 64'(e.sat));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_cnt", 64'(out_cnt), 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready_lo", 64'(in_ready), 64'd0);
    tick();
    chk("rel_ready_hi", 64'(in_ready), 64'd1);

    // Test 1: 1..8 back-to-back, result one cycle after the 8th beat
    push(32'd36, 8, 1'b0);
    for (int i = 1; i <= 8; i++) beat(32'(i), 1'b0, 1'b0);
    chk("t1_latency", 64'(out_valid), 64'd1);
    collect("t1");

    // Test 2: early close with in_last
    push(32'd5, 3, 1'b0);
    beat(-32'sd5, 1'b0, 1'b0);
    beat(-32'sd10, 1'b0, 1'b0);
    beat(32'd20, 1'b1, 1'b0);
    collect("t2");

    // Test 3: back-pressure holds the result
    push(32'd80, 8, 1'b0);
    for (int i = 0; i < 8; i++) beat(32'd10, 1'b0, 1'b0);
    held = out_sum;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_sum", 64'(out_sum), 64'(held));
      chk("t3_hold_rdy", 64'(in_ready), 64'd0);
      chk("t3_hold_vld", 64'(out_valid), 64'd1);
    end
    tick();
    collect("t3");

    // Test 4: large positive sum, saturating or wrapping
`ifdef BOOTH_ACCUM_SAT_EN
    push(32'h7FFF_FFFF, 8, 1'b1);
`else
    push(32'hFFF8_0000, 8, 1'b0);
`endif
    for (int i = 0; i < 8; i++) beat(32'h7FFF_0000, 1'b0, 1'b0);
    collect("t4");

    // Test 5: reset mid-frame discards the partial sum
    for (int i = 0; i < 5; i++) beat(32'd100, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_rst_vld", 64'(out_valid), 64'd0);
    chk("t5_rst_rdy", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_no_out", 64'(out_valid), 64'd0);
    push(32'd8, 8, 1'b0);
    for (int i = 0; i < 8; i++) beat(32'd1, 1'b0, 1'b0);
    collect("t5");

    // Test 6: clr with the 4th beat drops the frame, including that beat
    for (int i = 0; i < 3; i++) beat(32'd7, 1'b0, 1'b0);
    beat(32'd7, 1'b0, 1'b1);
    chk("t6_clr_vld", 64'(out_valid), 64'd0);
    push(32'd16, 8, 1'b0);
    for (int i = 0; i < 8; i++) beat(32'd2, 1'b0, 1'b0);
    collect("t6");

    // clr in HOLD retires the result without a handshake
    for (int i = 0; i < 8; i++) beat(32'd3, 1'b0, 1'b0);
    chk("hold_clr_pre", 64'(out_valid), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("hold_clr_vld", 64'(out_valid), 64'd0);
    chk("hold_clr_rdy", 64'(in_ready), 64'd1);

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
